// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// states and the iteration counter width.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} mdu_state_e;

  function automatic int mdu_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_w(32);

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not borrow.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {2'b00, dvsr_i};
  // The top bit of the wider difference is the borrow of the trial subtract.
  assign q_o     = ~diff[WIDTH+1];
  assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO write data and strobes.
// Results are registered out of FINISH, so done/strobes show one cycle later.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_in,
  output logic [WIDTH-1:0] lo_in,
  output logic             hi_write,
  output logic             lo_write
);

  localparam int CW = mdu_cnt_w(WIDTH);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  // Mul: {partial product, multiplier}. Div: low half is dividend -> quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dzo_q, dzo_d;
  logic               wr_q, wr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign div_op    = (op == MDU_DIV) || (op == MDU_DIVU);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_abs     = a_neg ? (~a + 1'b1) : a;
  assign b_abs     = b_neg ? (~b + 1'b1) : b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (acc_q[WIDTH-1]),
    .dvsr_i (opb_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  assign prod_fix = neg_q  ? (~acc_q + 1'b1)               : acc_q;
  assign quo_fix  = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1)    : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1)    : rem_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    done_d   = 1'b0;
    dzo_d    = 1'b0;
    wr_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        // busy_q still covers the visible done cycle, where start is ignored.
        if (start && !busy_q) begin
          cnt_d    = '0;
          is_div_d = div_op;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          rem_d    = '0;
          dz_d     = 1'b0;
          if (!div_op) begin
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            opb_d   = a_abs;
            state_d = MUL;
          end else begin
            acc_d = {{WIDTH{1'b0}}, a_abs};
            opb_d = b_abs;
            if (b == '0) begin
              dz_d    = 1'b1;
              state_d = FINISH;
            end else begin
              state_d = DIV;
            end
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      DIV: begin
        rem_d = step_rem;
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          dzo_d = 1'b1;
        end else begin
          wr_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (state_q == FINISH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi_in    = hi_q;
  assign lo_in    = lo_q;
  assign hi_write = wr_q;
  assign lo_write = wr_q;

endmodule
